// File: rtl/dma_rd_arb_pkg.sv
// Shared types and helpers for the DMA read-channel arbiter and its round-robin picker.
package dma_arb_pkg;
  localparam int ADDR_MAX = 64;
  localparam int ID_MAX   = 16;
  localparam int NREQ_MAX = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [7:0]          len;
    logic [ID_MAX-1:0]   id;
  } ar_payload_t;

  // Index width that tags ARID with the requester number; never narrower than one bit.
  function automatic int ixw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... modulo n. Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n);
    logic       found;
    logic [2:0] idx;
    int         j;
    found = 1'b0;
    idx   = 3'd0;
    j     = 0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < n && !found) begin
        j = (int'(ptr) + k) % n;
        if (req[j[2:0]]) begin
          found = 1'b1;
          idx   = j[2:0];
        end
      end
    end
    return {found, idx};
  endfunction
endpackage

// File: rtl/dma_rd_arb_if.sv
// AXI read bundle of the arbiter: requester-side (s_*) and interconnect-side (m_*) signals.
// Valid/ready: a transfer happens on a cycle where valid and ready are both 1; a raised
// valid holds its payload stable until accepted, and ready may depend combinationally on valid.
interface dma_rd_arb_if
  import dma_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 64,
  parameter int IDW  = 4
);
  localparam int IXW = ixw_f(NREQ);

  logic [NREQ-1:0]     s_arvalid;
  logic [NREQ-1:0]     s_arready;
  logic [NREQ*AW-1:0]  s_araddr;
  logic [NREQ*8-1:0]   s_arlen;
  logic [NREQ*IDW-1:0] s_arid;
  logic                m_arvalid;
  logic                m_arready;
  logic [AW-1:0]       m_araddr;
  logic [7:0]          m_arlen;
  logic [IDW+IXW-1:0]  m_arid;
  logic                m_rvalid;
  logic                m_rready;
  logic [DW-1:0]       m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic [IDW+IXW-1:0]  m_rid;
  logic [NREQ-1:0]     s_rvalid;
  logic [NREQ-1:0]     s_rready;
  logic [DW-1:0]       s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic [IDW-1:0]      s_rid;

  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_arid, m_arready,
           m_rvalid, m_rdata, m_rresp, m_rlast, m_rid, s_rready,
    output s_arready, m_arvalid, m_araddr, m_arlen, m_arid,
           m_rready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );

  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_arid, m_arready,
           m_rvalid, m_rdata, m_rresp, m_rlast, m_rid, s_rready,
    input  s_arready, m_arvalid, m_araddr, m_arlen, m_arid,
           m_rready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );
endinterface

// File: rtl/dma_rd_arb_rr_picker.sv
// Combinational round-robin priority encoder; shared with the write-channel arbiter.
module dma_rr_picker
  import dma_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = ixw_f(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);
  logic [3:0] pick;
  logic       unused_pick;

  assign pick        = rr_pick(8'(req_i), 3'(ptr_i), N);
  assign found_o     = pick[3];
  assign idx_o       = pick[PW-1:0];
  assign unused_pick = ^pick;
endmodule

// File: rtl/dma_rd_arb.sv
// Shares one AXI read master between NREQ DMA requesters: round-robin AR arbitration with
// ARID tagging, RID-based R routing and a per-requester outstanding-burst limit.
module dma_rd_arb
  import dma_arb_pkg::*;
#(
  parameter  int NREQ     = 2,
  parameter  int AW       = 32,
  parameter  int DW       = 64,
  parameter  int IDW      = 4,
  parameter  int MAX_OUTS = 4,
  localparam int IXW      = ixw_f(NREQ),
  localparam int CW       = $clog2(MAX_OUTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  dma_rd_arb_if.master       bus,
  output logic               err_unroutable,
  output arb_state_e         dbg_state_o,
  output logic [IXW-1:0]     dbg_rr_o,
  output logic [NREQ*CW-1:0] dbg_outs_o
);
  arb_state_e      state_q;
  logic            m_arvalid_q;
  ar_payload_t     pl_q;
  logic [IXW-1:0]  rr_q;
  logic [CW-1:0]   outs_q [NREQ];
  logic [CW-1:0]   outs_d [NREQ];
  logic            err_q;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IXW-1:0]  win;
  logic            grant;
  logic [IXW-1:0]  ridx;
  logic            routable;
  logic            r_hs;
  logic            r_done;
  logic            unused_pl;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.s_arvalid[i] && (outs_q[i] < CW'(MAX_OUTS));
    end
  end

  dma_rr_picker #(.N(NREQ)) u_pick (
    .req_i  (elig),
    .ptr_i  (rr_q),
    .found_o(found),
    .idx_o  (win)
  );

  // The grant pulse is combinational so the requester sees its ready in the request cycle.
  assign grant         = (state_q == ST_IDLE) && found && !rst;
  assign bus.s_arready = grant ? (NREQ'(1) << win) : '0;

  assign ridx = bus.m_rid[IDW+IXW-1:IDW];
  if (NREQ == (1 << IXW)) begin : g_all_routable
    assign routable = 1'b1;
  end else begin : g_some_unroutable
    assign routable = (ridx < IXW'(NREQ));
  end

  // Beats tagged with a nonexistent requester are sunk so the interconnect never stalls.
  assign bus.m_rready = routable ? bus.s_rready[ridx] : 1'b1;
  assign bus.s_rvalid = (routable && bus.m_rvalid) ? (NREQ'(1) << ridx) : '0;
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;
  assign bus.s_rid    = bus.m_rid[IDW-1:0];
  assign r_hs         = bus.m_rvalid && bus.m_rready;
  assign r_done       = r_hs && bus.m_rlast && routable;

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      inc       = grant && (win == IXW'(i));
      dec       = r_done && (ridx == IXW'(i));
      outs_d[i] = outs_q[i];
      if (inc && !dec) begin
        outs_d[i] = outs_q[i] + CW'(1);
      end else if (dec && !inc && (outs_q[i] != '0)) begin
        outs_d[i] = outs_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_arvalid_q <= 1'b0;
      pl_q        <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NREQ; i++) outs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) outs_q[i] <= outs_d[i];
      if (r_hs && !routable) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            pl_q.addr   <= ADDR_MAX'(bus.s_araddr[int'(win)*AW +: AW]);
            pl_q.len    <= bus.s_arlen[int'(win)*8 +: 8];
            pl_q.id     <= ID_MAX'({win, bus.s_arid[int'(win)*IDW +: IDW]});
            m_arvalid_q <= 1'b1;
            state_q     <= ST_ISSUE;
            rr_q        <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_arvalid  = m_arvalid_q;
  assign bus.m_araddr   = pl_q.addr[AW-1:0];
  assign bus.m_arlen    = pl_q.len;
  assign bus.m_arid     = pl_q.id[IDW+IXW-1:0];
  assign err_unroutable = err_q;
  assign dbg_state_o    = state_q;
  assign dbg_rr_o       = rr_q;
  assign unused_pl      = ^{pl_q.addr, pl_q.id};

  for (genvar g = 0; g < NREQ; g++) begin : g_dbg_outs
    assign dbg_outs_o[g*CW +: CW] = outs_q[g];
  end
endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed bench for dma_rd_arb: a two-requester instance for arbitration, limits and
// routing, plus a three-requester instance for the unroutable-ID path.
module tb_dma_rd_arb;
  import dma_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_a, err_b;
  arb_state_e st_a, st_b;
  logic [0:0] rr_a;
  logic [1:0] rr_b;
  logic [5:0] outs_a;
  logic [8:0] outs_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dma_rd_arb_if #(.NREQ(2), .AW(AW), .DW(DW), .IDW(IDW)) bus_a ();
  dma_rd_arb_if #(.NREQ(3), .AW(AW), .DW(DW), .IDW(IDW)) bus_b ();

  dma_rd_arb #(.NREQ(2), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTS(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .err_unroutable(err_a),
    .dbg_state_o(st_a), .dbg_rr_o(rr_a), .dbg_outs_o(outs_a)
  );

  dma_rd_arb #(.NREQ(3), .AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTS(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .err_unroutable(err_b),
    .dbg_state_o(st_b), .dbg_rr_o(rr_b), .dbg_outs_o(outs_b)
  );

  typedef struct {
    logic       rvalid;
    logic [4:0] rid;
    logic [1:0] srdy;
    logic [1:0] exp_sv;
    logic       exp_mr;
  } rvec_t;

  rvec_t rtab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.s_arvalid = '0; bus_a.s_araddr = '0; bus_a.s_arlen = '0; bus_a.s_arid = '0;
    bus_a.m_arready = 1'b0; bus_a.m_rvalid = 1'b0; bus_a.m_rdata = '0; bus_a.m_rresp = '0;
    bus_a.m_rlast = 1'b0; bus_a.m_rid = '0; bus_a.s_rready = '0;
    bus_b.s_arvalid = '0; bus_b.s_araddr = '0; bus_b.s_arlen = '0; bus_b.s_arid = '0;
    bus_b.m_arready = 1'b0; bus_b.m_rvalid = 1'b0; bus_b.m_rdata = '0; bus_b.m_rresp = '0;
    bus_b.m_rlast = 1'b0; bus_b.m_rid = '0; bus_b.s_rready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rtab[0] = '{1'b1, 5'h03, 2'b01, 2'b01, 1'b1};
    rtab[1] = '{1'b1, 5'h13, 2'b01, 2'b10, 1'b0};
    rtab[2] = '{1'b1, 5'h13, 2'b10, 2'b10, 1'b1};
    rtab[3] = '{1'b0, 5'h10, 2'b11, 2'b00, 1'b1};
    rtab[4] = '{1'b1, 5'h0f, 2'b10, 2'b01, 1'b0};
    rtab[5] = '{1'b0, 5'h00, 2'b00, 2'b00, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_m_arvalid", 64'(bus_a.m_arvalid), 64'd0);
    chk("rst_s_arready", 64'(bus_a.s_arready), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_m_araddr", 64'(bus_a.m_araddr), 64'd0);
    chk("rst_m_arid", 64'(bus_a.m_arid), 64'd0);
    chk("rst_m_arlen", 64'(bus_a.m_arlen), 64'd0);
    chk("rst_state", 64'(st_a), 64'(ST_IDLE));
    chk("rst_rr", 64'(rr_a), 64'd0);
    chk("rst_outs", 64'(outs_a), 64'd0);

    // Single request from requester 0 and its 8-beat burst
    bus_a.s_arvalid = 2'b01;
    bus_a.s_araddr[31:0] = 32'h1000;
    bus_a.s_arlen[7:0] = 8'd7;
    bus_a.s_arid[3:0] = 4'h3;
    bus_a.m_arready = 1'b1;
    #1;
    chk("single_grant", 64'(bus_a.s_arready), 64'b01);
    tick();
    bus_a.s_arvalid = 2'b00;
    #1;
    chk("single_arvalid", 64'(bus_a.m_arvalid), 64'd1);
    chk("single_arid", 64'(bus_a.m_arid), 64'h03);
    chk("single_araddr", 64'(bus_a.m_araddr), 64'h1000);
    chk("single_arlen", 64'(bus_a.m_arlen), 64'd7);
    chk("single_issue_no_ready", 64'(bus_a.s_arready), 64'd0);
    chk("single_outs_inc", 64'(outs_a), {58'd0, 3'd0, 3'd1});
    tick();
    #1;
    chk("single_ar_done", 64'(bus_a.m_arvalid), 64'd0);
    chk("single_idle", 64'(st_a), 64'(ST_IDLE));
    bus_a.s_rready = 2'b11;
    for (int b = 0; b < 8; b++) begin
      bus_a.m_rvalid = 1'b1;
      bus_a.m_rid = 5'h03;
      bus_a.m_rlast = (b == 7);
      bus_a.m_rdata = 64'(100 + b);
      #1;
      chk("single_r_route", 64'(bus_a.s_rvalid), 64'b01);
      chk("single_r_data", 64'(bus_a.s_rdata), 64'(100 + b));
      chk("single_r_rid", 64'(bus_a.s_rid), 64'h3);
      chk("single_r_ready", 64'(bus_a.m_rready), 64'd1);
      if (b == 6) chk("single_outs_mid", 64'(outs_a), {58'd0, 3'd0, 3'd1});
      tick();
    end
    bus_a.m_rvalid = 1'b0;
    bus_a.m_rlast = 1'b0;
    #1;
    chk("single_outs_back", 64'(outs_a), 64'd0);

    // Fairness: both requesting, six grants alternate
    do_reset();
    bus_a.s_araddr = {32'h3000, 32'h2000};
    bus_a.s_arid = {4'h2, 4'h1};
    bus_a.s_arvalid = 2'b11;
    bus_a.m_arready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("fair_grant", 64'(bus_a.s_arready), (g % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      #1;
      chk("fair_arid", 64'(bus_a.m_arid), (g % 2 == 0) ? 64'h01 : 64'h12);
      chk("fair_araddr", 64'(bus_a.m_araddr), (g % 2 == 0) ? 64'h2000 : 64'h3000);
      tick();
    end

    // Outstanding limit on requester 1
    do_reset();
    bus_a.s_araddr = {32'h6000, 32'h7000};
    bus_a.s_arid = {4'h4, 4'h6};
    bus_a.s_arvalid = 2'b10;
    bus_a.m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("limit_fill", 64'(bus_a.s_arready), 64'b10);
      tick();
      tick();
    end
    #1;
    chk("limit_outs4", 64'(outs_a), {58'd0, 3'd4, 3'd0});
    bus_a.s_arvalid = 2'b11;
    #1;
    chk("limit_req0_a", 64'(bus_a.s_arready), 64'b01);
    tick();
    tick();
    #1;
    chk("limit_req0_b", 64'(bus_a.s_arready), 64'b01);
    tick();
    tick();
    bus_a.s_arvalid = 2'b10;
    #1;
    chk("limit_stall", 64'(bus_a.s_arready), 64'b00);
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid = 5'h14;
    bus_a.m_rlast = 1'b1;
    bus_a.s_rready = 2'b10;
    #1;
    chk("limit_r_ready", 64'(bus_a.m_rready), 64'd1);
    chk("limit_r_route", 64'(bus_a.s_rvalid), 64'b10);
    tick();
    bus_a.m_rvalid = 1'b0;
    bus_a.m_rlast = 1'b0;
    bus_a.s_arvalid = 2'b11;
    #1;
    chk("limit_outs_after", 64'(outs_a), {58'd0, 3'd3, 3'd2});
    chk("limit_resume", 64'(bus_a.s_arready), 64'b10);
    tick();
    tick();

    // AR backpressure: payload frozen while m_arready is low
    do_reset();
    bus_a.s_arvalid = 2'b01;
    bus_a.s_araddr[31:0] = 32'h4000;
    bus_a.s_arlen[7:0] = 8'd3;
    bus_a.s_arid[3:0] = 4'h5;
    #1;
    chk("bp_grant", 64'(bus_a.s_arready), 64'b01);
    tick();
    bus_a.s_arvalid = 2'b11;
    bus_a.s_araddr[31:0] = 32'h5000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_arvalid", 64'(bus_a.m_arvalid), 64'd1);
      chk("bp_araddr", 64'(bus_a.m_araddr), 64'h4000);
      chk("bp_arid", 64'(bus_a.m_arid), 64'h05);
      chk("bp_no_ready", 64'(bus_a.s_arready), 64'd0);
      tick();
    end
    bus_a.m_arready = 1'b1;
    bus_a.s_arvalid = 2'b00;
    tick();
    #1;
    chk("bp_release", 64'(bus_a.m_arvalid), 64'd0);
    chk("bp_idle", 64'(st_a), 64'(ST_IDLE));
    bus_a.m_arready = 1'b0;

    // R backpressure from requester 1
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid = 5'h12;
    bus_a.s_rready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rbp_mready_low", 64'(bus_a.m_rready), 64'd0);
      chk("rbp_route", 64'(bus_a.s_rvalid), 64'b10);
      tick();
    end
    bus_a.s_rready = 2'b11;
    #1;
    chk("rbp_mready_high", 64'(bus_a.m_rready), 64'd1);
    tick();
    bus_a.m_rvalid = 1'b0;

    // R routing table
    for (int i = 0; i < 6; i++) begin
      bus_a.m_rvalid = rtab[i].rvalid;
      bus_a.m_rid = rtab[i].rid;
      bus_a.s_rready = rtab[i].srdy;
      #1;
      chk("tab_s_rvalid", 64'(bus_a.s_rvalid), 64'(rtab[i].exp_sv));
      chk("tab_m_rready", 64'(bus_a.m_rready), 64'(rtab[i].exp_mr));
      chk("tab_s_rid", 64'(bus_a.s_rid), 64'(rtab[i].rid[3:0]));
      tick();
    end
    bus_a.m_rvalid = 1'b0;

    // Stray last beat with nothing outstanding saturates at zero
    do_reset();
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid = 5'h00;
    bus_a.m_rlast = 1'b1;
    bus_a.s_rready = 2'b01;
    #1;
    chk("sat_mready", 64'(bus_a.m_rready), 64'd1);
    tick();
    bus_a.m_rvalid = 1'b0;
    bus_a.m_rlast = 1'b0;
    #1;
    chk("sat_outs", 64'(outs_a), 64'd0);
    chk("sat_no_err", 64'(err_a), 64'd0);

    // Unroutable index on the three-requester instance
    bus_b.m_rvalid = 1'b1;
    bus_b.m_rid = 6'h30;
    bus_b.s_rready = 3'b000;
    #1;
    chk("unr_mready", 64'(bus_b.m_rready), 64'd1);
    chk("unr_no_rvalid", 64'(bus_b.s_rvalid), 64'd0);
    chk("unr_err_not_yet", 64'(err_b), 64'd0);
    tick();
    bus_b.m_rvalid = 1'b0;
    #1;
    chk("unr_err_set", 64'(err_b), 64'd1);
    bus_b.m_rvalid = 1'b1;
    bus_b.m_rid = 6'h25;
    bus_b.s_rready = 3'b100;
    #1;
    chk("unr_route_idx2", 64'(bus_b.s_rvalid), 64'b100);
    chk("unr_rid_idx2", 64'(bus_b.s_rid), 64'h5);
    chk("unr_ready_idx2", 64'(bus_b.m_rready), 64'd1);
    tick();
    bus_b.m_rvalid = 1'b0;
    tick();
    #1;
    chk("unr_err_sticky", 64'(err_b), 64'd1);
    do_reset();
    #1;
    chk("unr_err_cleared", 64'(err_b), 64'd0);

    // Reset while a burst is waiting in ISSUE
    bus_a.s_arvalid = 2'b01;
    bus_a.m_arready = 1'b0;
    #1;
    chk("rsti_grant", 64'(bus_a.s_arready), 64'b01);
    tick();
    #1;
    chk("rsti_issue", 64'(bus_a.m_arvalid), 64'd1);
    chk("rsti_rr_before", 64'(rr_a), 64'd1);
    rst = 1'b1;
    bus_a.s_arvalid = 2'b11;
    tick();
    #1;
    chk("rsti_arvalid", 64'(bus_a.m_arvalid), 64'd0);
    chk("rsti_state", 64'(st_a), 64'(ST_IDLE));
    chk("rsti_rr", 64'(rr_a), 64'd0);
    chk("rsti_no_ready_in_rst", 64'(bus_a.s_arready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rsti_first_grant", 64'(bus_a.s_arready), 64'b01);
    bus_a.m_arready = 1'b1;
    tick();
    bus_a.s_arvalid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dma_rd_arb.md
Name: dma_rd_arb

Overview:
- Shares one AXI4 read master port between NREQ DMA read requesters, for example the MM2S data read and the scatter-gather descriptor fetch.
- Sits between the DMA engine read ports and the CPU-side AXI read interconnect.
- Arbitrates the AR channel round-robin and tags ARID with the requester index.
- Routes R beats back by RID tag, and enforces a per-requester outstanding-burst limit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 64, data width.
- IDW, 4, requester-side ID width.
- MAX_OUTS, 4, maximum outstanding bursts per requester (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_arvalid  in  NREQ  per-requester AR valid.
- s_arready  out  NREQ  per-requester AR ready.
- s_araddr  in  NREQ*AW  packed AR address, requester i at [i*AW +: AW].
- s_arlen  in  NREQ*8  packed burst length.
- s_arid  in  NREQ*IDW  packed ID.
- m_arvalid  out  1  master AR valid.
- m_arready  in  1  master AR ready.
- m_araddr  out  AW  master address.
- m_arlen  out  8  master burst length.
- m_arid  out  IDW+IXW  {requester index, s_arid}; IXW = max(1, clog2(NREQ)).
- m_rvalid  in  1  master R valid.
- m_rready  out  1  master R ready.
- m_rdata  in  DW  read data.
- m_rresp  in  2  read response.
- m_rlast  in  1  last beat.
- m_rid  in  IDW+IXW  returned ID.
- s_rvalid  out  NREQ  per-requester R valid.
- s_rready  in  NREQ  per-requester R ready.
- s_rdata  out  DW  broadcast data.
- s_rresp  out  2  broadcast response.
- s_rlast  out  1  broadcast last.
- s_rid  out  IDW  m_rid low IDW bits.
- err_unroutable  out  1  sticky flag: R beat received with index >= NREQ.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - outputs: m_arvalid=0, s_arready=0, err_unroutable=0, m_araddr/m_arlen/m_arid=0;
  - internal: state=IDLE, round-robin pointer rr=0, all outstanding counts=0.
  - Reset mid-burst discards all tracking; the bench must reset the slave side too.
- Eligibility: requester i is eligible when s_arvalid[i]=1 and outs[i] < MAX_OUTS.
- FSM IDLE:
  - If any requester is eligible, the winner is the first eligible index scanning rr, rr+1, ... modulo NREQ.
  - Same cycle: s_arready[winner]=1 (combinational, one-cycle pulse) and the winner's payload is latched into the m_ar registers.
  - Next cycle: m_arvalid=1, state goes to ISSUE, rr=(winner+1) mod NREQ, outs[winner] increments.
- FSM ISSUE:
  - m_arvalid held at 1 with a stable payload until m_arready=1.
  - Then m_arvalid=0 next cycle and state returns to IDLE.
  - All s_arready=0 while in ISSUE.
- AR throughput: at most one burst per 2 cycles. Latency from s_arvalid to m_arvalid is 1 cycle when idle.
- R routing, purely combinational:
  - idx = m_rid[IDW+IXW-1:IDW].
  - If idx < NREQ: s_rvalid[idx]=m_rvalid, others 0, and m_rready=s_rready[idx].
  - If idx >= NREQ: m_rready=1 (beat sunk), all s_rvalid=0, and err_unroutable is set on the handshake; it clears only on rst.
- Outstanding count decrement: on m_rvalid & m_rready & m_rlast with idx < NREQ, outs[idx] decrements.
- Same-requester grant and last-beat in one cycle: net change 0.
- Counter width: clog2(MAX_OUTS+1). Counts never wrap; decrementing at 0 (protocol error) saturates at 0.
- Starvation freedom: a continuously eligible requester is granted within NREQ grants.

Decomposition:
- dma_arb_pkg holds:
  - function rr_pick(req vector, pointer) returning {found, index};
  - localparam for the IXW computation;
  - typedef ar_payload_t {addr, len, id}.
- One sub-module, dma_rr_picker: parameterised round-robin priority encoder (combinational), reused later by the write-channel arbiter.
- All FSM and counter logic lives in dma_rd_arb.

Test Plan:
- Single request:
  - Stimulus: NREQ=2, req0 araddr=0x1000, arlen=7, arid=3; m_arready=1.
  - Required: s_arready[0] pulses at cycle 0; m_arvalid at cycle 1 with m_arid=0x03 and m_araddr=0x1000; 8 R beats with rid=0x03 reach only s_rvalid[0]; outs[0] returns to 0 after the rlast beat.
- Fairness:
  - Stimulus: both requesters hold arvalid for 6 grants.
  - Required: grant order 0,1,0,1,0,1; m_arid upper bit alternates.
- Outstanding limit:
  - Stimulus: MAX_OUTS=4; req1 issues 4 bursts with no R returned; req0 also requests.
  - Required: 5th req1 request is stalled while req0 is still granted; after one req1 rlast, req1 is granted next.
- Backpressure:
  - Stimulus: m_arready=0 for 5 cycles.
  - Required: m_arvalid and payload held stable, no s_arready asserted; m_arready=1 ends ISSUE.
  - Stimulus: s_rready[1]=0 while R beats for idx 1 arrive.
  - Required: m_rready=0 until s_rready[1]=1.
- Unroutable ID:
  - Stimulus: NREQ=3, m_rid index=3.
  - Required: m_rready=1, no s_rvalid asserted, err_unroutable=1 from the next cycle until rst.
- Reset in ISSUE:
  - Stimulus: assert rst while m_arvalid=1.
  - Required: m_arvalid=0 on the next clk edge; rr=0; first post-reset grant goes to req0 when all requesters request.
